// File: rtl/popcount_pkg.sv
// Shared helpers and constants for the pipelined population counter.
// Provides clog2, the count-mode encodings and the chunk-count helper.
package popcount_pkg;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int calc_nch(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice; no state, no latency.
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]             chunk_i,
  output logic [clog2(CHUNK+1)-1:0]    count_o
);

  localparam int PW = clog2(CHUNK + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count_o = count_o + PW'(chunk_i[i]);
    end
  end

endmodule

// File: rtl/popcount_pipe.sv
// Two-stage pipelined ones/zeros counter with valid/ready on both sides, 2-cycle latency.
// Optional per-frame accumulator enabled by defining POPCNT_ACCUM_EN.
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8,
  parameter int ACC_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_mode,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [clog2(WIDTH+1)-1:0]   out_count,
  output logic                        out_last,
  output logic [ACC_W-1:0]            acc_count,
  output logic                        acc_sat
);

  localparam int NCH = calc_nch(WIDTH, CHUNK);
  localparam int PW  = clog2(CHUNK + 1);
  localparam int CW  = clog2(WIDTH + 1);

  logic                     s1_valid_q, s1_last_q;
  logic [NCH-1:0][PW-1:0]   part_q, part_d;
  logic                     out_valid_q, out_last_q;
  logic [CW-1:0]            out_count_q, sum_d;
  logic                     s1_load, s2_load;
  logic [NCH*CHUNK-1:0]     padded;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Padding is zeroed after inversion so zeros mode never counts it.
  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = (in_mode == MODE_ZEROS) ? ~in_data : in_data;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
      .chunk_i (padded[g*CHUNK +: CHUNK]),
      .count_o (part_d[g])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NCH; i++) begin
      sum_d = sum_d + CW'(part_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      part_q     <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        part_q    <= part_d;
        s1_last_q <= in_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_count_q <= sum_d;
        out_last_q  <= s1_last_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;

`ifdef POPCNT_ACCUM_EN
  localparam int SW = ((ACC_W > CW) ? ACC_W : CW) + 1;
  localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [ACC_W-1:0] run_q, run_d, acc_q;
  logic             run_sat_q, run_sat_d, acc_sat_q;
  logic [SW-1:0]    add_sum;
  logic             ovf;

  always_comb begin
    add_sum   = SW'(run_q) + SW'(out_count_q);
    ovf       = add_sum > ACC_MAX;
    run_d     = ovf ? {ACC_W{1'b1}} : add_sum[ACC_W-1:0];
    run_sat_d = run_sat_q | ovf;
  end

  // The frame total is published on the last word and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= '0;
      run_sat_q <= 1'b0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
    end else if (out_valid_q && out_ready) begin
      if (out_last_q) begin
        acc_q     <= run_d;
        acc_sat_q <= run_sat_d;
        run_q     <= '0;
        run_sat_q <= 1'b0;
      end else begin
        run_q     <= run_d;
        run_sat_q <= run_sat_d;
      end
    end
  end

  assign acc_count = acc_q;
  assign acc_sat   = acc_sat_q;
`else
  assign acc_count = '0;
  assign acc_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: 16-bit scoreboarded DUT (ACC_W=5) plus a 12-bit padding DUT.
module tb_popcount_pipe;

  localparam int ACC_MAX_TB = 31;

  logic        clk, reset;
  logic        in_valid, in_ready, in_mode, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [4:0]  out_count;
  logic [4:0]  acc_count;
  logic        acc_sat;

  logic        v2, ir2, m2, l2, ov2, ol2;
  logic [11:0] d2;
  logic [3:0]  cnt2;
  logic [15:0] ac2;
  logic        as2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   cnt;
    logic last;
  } exp_t;

  exp_t sb[$];

  popcount_pipe #(.WIDTH(16), .CHUNK(8), .ACC_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_last(out_last), .acc_count(acc_count), .acc_sat(acc_sat)
  );

  popcount_pipe #(.WIDTH(12), .CHUNK(8)) dut12 (
    .clk(clk), .reset(reset),
    .in_valid(v2), .in_ready(ir2), .in_data(d2),
    .in_mode(m2), .in_last(l2),
    .out_valid(ov2), .out_ready(1'b1), .out_count(cnt2),
    .out_last(ol2), .acc_count(ac2), .acc_sat(as2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard / accumulator model, sampled on the falling edge.
  int          run_m = 0;
  logic        rsat_m = 1'b0;
  logic        acc_pend = 1'b0;
  int          acc_exp = 0;
  logic        sat_exp = 1'b0;
  logic        have_hold = 1'b0;
  logic [4:0]  hold_cnt;
  logic        hold_last;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      run_m = 0; rsat_m = 1'b0; acc_pend = 1'b0; have_hold = 1'b0;
    end else begin
      if (acc_pend) begin
        chk("acc_count", 32'(acc_count), 32'(acc_exp));
        chk("acc_sat", 32'(acc_sat), 32'(sat_exp));
        acc_pend = 1'b0;
      end
      if (have_hold) begin
        chk("hold_vld", 32'(out_valid), 1);
        chk("hold_cnt", 32'(out_count), 32'(hold_cnt));
        chk("hold_last", 32'(out_last), 32'(hold_last));
      end
      have_hold = out_valid && !out_ready;
      hold_cnt  = out_count;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_count", 32'(out_count), 32'(e.cnt));
          chk("out_last", 32'(out_last), 32'(e.last));
          run_m = run_m + e.cnt;
          if (run_m > ACC_MAX_TB) begin
            run_m = ACC_MAX_TB;
            rsat_m = 1'b1;
          end
          if (e.last) begin
`ifdef POPCNT_ACCUM_EN
            acc_exp = run_m;
            sat_exp = rsat_m;
`else
            acc_exp = 0;
            sat_exp = 1'b0;
`endif
            acc_pend = 1'b1;
            run_m = 0;
            rsat_m = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.cnt  = $countones(in_mode ? ~in_data : in_data);
        n.last = in_last;
        sb.push_back(n);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic m, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic lat16(input logic [15:0] d, input logic m, input int exp);
    in_valid = 1'b1; in_data = d; in_mode = m; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_vld", 32'(out_valid), 1);
    chk("lat_cnt", 32'(out_count), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic lat12(input logic [11:0] d, input logic m, input int exp);
    v2 = 1'b1; d2 = d; m2 = m;
    @(posedge clk); #1;
    v2 = 1'b0;
    @(negedge clk);
    chk("w12_early", 32'(ov2), 0);
    @(negedge clk);
    chk("w12_vld", 32'(ov2), 1);
    chk("w12_cnt", 32'(cnt2), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_rdy, vld_cnt, stale;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; v2 = 1'b0; d2 = '0; m2 = 1'b0; l2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_acc", 32'(acc_count), 0);
    chk("rst_acc_sat", 32'(acc_sat), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Ones mode basics with exact 2-cycle latency.
    lat16(16'hFFFF, 1'b0, 16);
    lat16(16'h0000, 1'b0, 0);
    lat16(16'hA5A5, 1'b0, 8);
    lat16(16'h0000, 1'b1, 16);

    // Zeros mode with padding on the 12-bit instance.
    chk("w12_in_ready", 32'(ir2), 1);
    lat12(12'h000, 1'b1, 12);
    lat12(12'hF0F, 1'b1, 4);
    lat12(12'hFFF, 1'b0, 12);
    drain();

    // Full throughput: 20 back-to-back words.
    low_rdy = 0; vld_cnt = 0;
    in_valid = 1'b1; in_data = 16'(0); in_mode = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k < 20 && !in_ready) low_rdy++;
      if (k >= 2 && out_valid) vld_cnt++;
      @(posedge clk); #1;
      if (k + 1 < 20) in_data = 16'($urandom);
      else in_valid = 1'b0;
    end
    chk("thru_in_ready_low", 32'(low_rdy), 0);
    chk("thru_out_valid", 32'(vld_cnt), 20);
    drain();

    // Backpressure: 1..10 set bits, 5-cycle stall mid-stream.
    fork
      begin
        for (int i = 1; i <= 10; i++) send(16'((32'h1 << i) - 1), 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_inflight", sb.size(), 2);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(16'h00FF, 1'b0, 1'b0);
    send(16'h0F0F, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    chk("mid_rst_stale", 32'(stale), 0);
    @(posedge clk); #1;

    // Frame totals: saturating frame, then a small frame.
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1);
    drain();
`ifdef POPCNT_ACCUM_EN
    chk("frame1_acc", 32'(acc_count), 31);
    chk("frame1_sat", 32'(acc_sat), 1);
`else
    chk("frame1_acc", 32'(acc_count), 0);
    chk("frame1_sat", 32'(acc_sat), 0);
`endif
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0001, 1'b0, 1'b1);
    drain();
`ifdef POPCNT_ACCUM_EN
    chk("frame2_acc", 32'(acc_count), 2);
`else
    chk("frame2_acc", 32'(acc_count), 0);
`endif
    chk("frame2_sat", 32'(acc_sat), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/popcount_pipe.md
Name: popcount_pipe

Overview:
- Parametrised, pipelined population counter; successor to the fixed 16-bit, single-register bit counter.
- Counts ones or zeros, selected per word, in an input word of WIDTH bits.
- Two-stage pipeline (chunk counts, then sum) behind a valid/ready handshake on both sides, giving full throughput under backpressure.
- Used by link-quality and statistics blocks that need per-word weight and, optionally, per-frame totals.

Parameters:
- WIDTH, 16, input data width in bits (1..256).
- CHUNK, 8, bits per stage-1 partial counter (1..WIDTH).
- ACC_W, 16, accumulator width; used only with POPCNT_ACCUM_EN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  word to count.
- in_mode  in  1  0 = count ones, 1 = count zeros.
- in_last  in  1  last word of frame; passed through; used by the accumulator.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_count  out  CW  count, where CW = clog2(WIDTH+1).
- out_last  out  1  in_last of the corresponding word.
- acc_count  out  ACC_W  frame total (POPCNT_ACCUM_EN only).
- acc_sat  out  1  frame total saturated (POPCNT_ACCUM_EN only).

Behaviour:
- Handshake rules:
  - A transfer occurs when valid && ready on a side.
  - in_data, in_mode and in_last are sampled only on an input transfer.
  - Once out_valid is high, out_* hold stable until out_ready.
- Stage 1 (s1): on accept, the word is inverted if in_mode = 1, then split into NCH = ceil(WIDTH/CHUNK) chunks. Each chunk is counted, and the partial counts and last are registered with s1_valid.
- Padding: bits beyond WIDTH in the final chunk are forced to 0 after inversion, so zeros mode never counts padding.
- Stage 2: partial counts are summed into out_count, out_last is registered, and out_valid is set.
- Advance logic:
  - s2_load = !out_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load, which is combinational from out_ready; there is no input-to-output combinational path for data.
- Latency and throughput:
  - Latency is exactly 2 cycles from the input transfer to out_valid with no stall.
  - Throughput is 1 word/cycle while out_ready = 1.
  - Under a stall, at most 2 words are held in flight and none are dropped or duplicated.
- Bubbles: if s1_valid = 0 when s2_load is high, out_valid drops after the current result is taken.
- Width rules:
  - out_count is max WIDTH; all-ones in ones mode gives WIDTH, and all-zeros in zeros mode gives WIDTH.
  - Partial counts are clog2(CHUNK+1) bits; the sum is CW bits with no overflow possible.
- Reset:
  - out_valid = 0, s1_valid = 0, out_count = 0, out_last = 0, acc_count = 0, acc_sat = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight words.
- Simultaneous events: an input transfer and an output transfer in the same cycle both complete, and the pipeline shifts.

Optional Feature:
- Macro: POPCNT_ACCUM_EN.
- With the macro defined:
  - A running sum of out_count is updated on each output transfer.
  - On an output transfer with out_last = 1, acc_count presents the frame total including that word and holds it until the next frame's last transfer. The running sum then clears to 0.
  - The sum saturates at 2^ACC_W-1; acc_sat is set for that frame and cleared with the sum.
  - A word that is both first and last yields acc_count = out_count.
- Without the macro: acc_count and acc_sat are tied to 0, and no accumulator registers exist.

Decomposition:
- Package popcount_pkg contains:
  - A clog2 function.
  - MODE_ONES = 1'b0 and MODE_ZEROS = 1'b1.
  - A function computing NCH from WIDTH and CHUNK.
- Sub-module popcount_chunk (parameter CHUNK) is a purely combinational count of one chunk. It is instantiated NCH times via generate in stage 1.

Test Plan:
- Ones mode, basic, defaults: in_data = 16'hFFFF, mode 0 → out_count = 16 exactly 2 cycles after accept. 16'h0000 → 0. 16'hA5A5 → 8.
- Zeros mode with padding, WIDTH = 12, CHUNK = 8: in_data = 12'h000, mode 1 → 12 (not 16). 12'hF0F, mode 1 → 4.
- Backpressure: a stream of 1..10 set bits with out_ready low for 5 cycles mid-stream:
  - in_ready drops after 2 words are held.
  - Outputs are in order 1..10 with no loss or duplication.
  - out_* are stable while stalled.
- Full throughput: 20 back-to-back words with out_ready = 1 → 20 consecutive out_valid cycles, and in_ready stays high.
- Reset mid-stream: assert reset with 2 words in flight → out_valid = 0 next cycle, and no stale result appears after release.
- POPCNT_ACCUM_EN, ACC_W = 5:
  - Frame of three 16'hFFFF words, last on the third → acc_count = 31, acc_sat = 1.
  - Next frame of 16'h0001 ×2 → acc_count = 2, acc_sat = 0.
